lynx_vfetch: RTL and testbench
==============================

# lynx_vfetch

Video fetch and pixel serialiser for the Lynx core. It owns the horizontal and vertical raster counters and drives the read-side address of the three video plane RAMs (red, green, blue). Those RAMs are dual-port, with read data registered one clock after the address. The block captures the plane bytes and shifts them out as 1-bit-per-plane RGB with aligned sync and blank. It sits between the VRAM read ports and the video output/scandoubler.

## Interface

Parameters:
- HA, 256: active pixels per line.
- HT, 384: total pixels per line.
- HS0, 296: hsync start (x).
- HS1, 328: hsync end (x, exclusive).
- VA, 248: active lines.
- VT, 312: total lines.
- VS0, 272: vsync start (y).
- VS1, 276: vsync end (y, exclusive).

Ports:
- clock, in, 1: system clock; same clock as the VRAM read port.
- reset, in, 1: asynchronous, active-low reset.
- ce, in, 1: pixel clock enable; all raster state advances only when ce=1.
- a, out, 13: VRAM read address {y[7:0], col[4:0]}, shared by all three planes.
- qr, in, 8: red plane read data.
- qg, in, 8: green plane read data.
- qb, in, 8: blue plane read data.
- qa, in, 8: alternate green plane data (only with LYNX_VFETCH_ALTGREEN_EN).
- altg, in, 1: alternate green select (only with LYNX_VFETCH_ALTGREEN_EN).
- r, g, b, out, 1 each: pixel outputs.
- hsync, out, 1: active-low horizontal sync.
- vsync, out, 1: active-low vertical sync.
- blank, out, 1: high outside the active area.

## Operation

- Counters:
  - x (9 bits) increments on ce and wraps HT-1 -> 0.
  - On that wrap, y (9 bits) increments and wraps VT-1 -> 0.
- Fetch:
  - Let fx = x+2, with fx taken modulo HT.
  - On a ce cycle where fx < HA, fx[2:0] = 0 and y < VA, register a <= {y[7:0], fx[7:3]}.
  - Outside those cycles, a holds its value.
  - On the x = HT-2 wrap-ahead, fx = 0 uses the same y. The line's first fetch therefore happens before x reaches 0 of that line, so it must use the y that will be current. Required: for fx in {0, 1} while x >= HT-2, use y+1, with wrap VT-1 -> 0.
- Load: on the ce cycle where x[2:0] = 7 (equivalently fx[2:0] = 1), and either:
  - the next group is active, or
  - x = HT-1 and the next line is active;

  load shift registers sr <= qr, sg <= qg, sb <= qb. Otherwise load zeros.
- Shift: on every other ce, shift each register left by 1. The MSB is pixel 0 of the group.
- Output register: on each ce, latch:
  - r/g/b <= MSBs of the current shifters;
  - blank <= !(x < HA && y < VA);
  - hsync <= !(HS0 <= x < HS1);
  - vsync <= !(VS0 <= y < VS1).

  All five outputs are therefore mutually aligned. r/g/b are forced to 0 when blank is 1.
- ce low: all registers hold, and a holds. RAM data is re-read harmlessly.

Reset values: x=0, y=0, a=0, shifters 0, r=g=b=0, hsync=1, vsync=1, blank=1.

## Timing

- RAM latency is 1 clock. a is updated at fx[2:0]=0. Data is consumed at the next ce (fx[2:0]=1), which is at least 1 clock later, so there is no stall at any ce rate, including ce tied high.
- Pixel at raster (x,y) appears on r/g/b one ce after the counter equals x+1, i.e. a fixed 2-ce pipeline from counter to pins. Sync and blank use the same delay.
- Reset mid-line: counters and outputs return to their reset values immediately (asynchronously). The first ce after release behaves as x=0, y=0. The first active group of line 0 is then blank, because its fetch was skipped; every later frame is normal.
- Boundary cases:
  - Last active group (x = HA-8..HA-1): no fetch for fx = HA.
  - Line VA-1 → VA: no fetches until line VT-1 wrap-ahead, which fetches line 0.

## Configuration

- LYNX_VFETCH_ALTGREEN_EN defined:
  - Ports qa and altg exist.
  - altg is sampled on the ce where x = HT-1 and held for the whole next line.
  - When the held value is 1, the green shifter loads qa instead of qg.
- LYNX_VFETCH_ALTGREEN_EN undefined:
  - qa and altg are absent.
  - Green always loads from qg.
  - No extra registers are present.

## Test plan

- Reset, ce=1 constant → hsync=vsync=blank=1 and r=g=b=0 until x=1. a=0 at the fetch where x=HT-2 of the first wrap. One frame spans exactly HT*VT = 119808 ce.
- RAM model filled with qr=0x80, qg=0x01, qb=0xFF at address 0 → on line 0:
  - r=1 only at pixel 0;
  - g=1 only at pixel 7;
  - b=1 on pixels 0..7;
  - all outputs 0 at pixel 8 when address 1 holds 0x00.
- Address sweep → a sequence per active line y is {y,0}..{y,31}. The first fetch of each line occurs at x=HT-2 of the previous line. No fetch occurs for y in VA..VT-2.
- ce asserted 1-in-4 clocks → pixel stream identical to the ce=1 run, sampled per ce. a changes only on ce cycles.
- Assert reset at x=100, y=50 for 3 clocks → outputs immediately hsync=vsync=blank=1. After release, the counters restart at 0,0, and the second frame is pixel-identical to the reference run.
- With LYNX_VFETCH_ALTGREEN_EN: qg=0x00, qa=0xFF, altg=1 at x=HT-1 of line 9 → g=1 across all of line 10. With altg=0, g=0 across line 11.

Source files
------------

// File: rtl/lynx_vfetch.sv
// Raster counters, VRAM fetch addressing and 1bpp RGB serialiser; 2-ce counter-to-pin pipeline, advances only on ce.
// Optional alternate green plane source is enabled by defining LYNX_VFETCH_ALTGREEN_EN.
module lynx_vfetch #(
  parameter int HA  = 256,
  parameter int HT  = 384,
  parameter int HS0 = 296,
  parameter int HS1 = 328,
  parameter int VA  = 248,
  parameter int VT  = 312,
  parameter int VS0 = 272,
  parameter int VS1 = 276
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  output logic [12:0] a,
  input  logic [7:0]  qr,
  input  logic [7:0]  qg,
  input  logic [7:0]  qb,
`ifdef LYNX_VFETCH_ALTGREEN_EN
  input  logic [7:0]  qa,
  input  logic        altg,
`endif
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank
);

  localparam logic [8:0] HA9  = 9'(HA);
  localparam logic [8:0] HT9  = 9'(HT);
  localparam logic [8:0] HS09 = 9'(HS0);
  localparam logic [8:0] HS19 = 9'(HS1);
  localparam logic [8:0] VA9  = 9'(VA);
  localparam logic [8:0] VT9  = 9'(VT);
  localparam logic [8:0] VS09 = 9'(VS0);
  localparam logic [8:0] VS19 = 9'(VS1);

  logic [8:0] x, y;
  logic [8:0] y_inc, fx, fy, nx, ny;
  logic       wrap_x, ahead, fetch, load, active, hs_on, vs_on;
  logic [7:0] sr, sg, sb;
  logic [7:0] g_src;

  always_comb begin
    wrap_x = (x == HT9 - 9'd1);
    ahead  = (x >= HT9 - 9'd2);
    y_inc  = (y == VT9 - 9'd1) ? 9'd0 : y + 9'd1;
    // Fetch runs two pixels ahead; near end of line it targets the next line.
    fx     = ahead ? x - (HT9 - 9'd2) : x + 9'd2;
    fy     = ahead ? y_inc : y;
    nx     = wrap_x ? 9'd0 : x + 9'd1;
    ny     = wrap_x ? y_inc : y;
    fetch  = (fx < HA9) && (fx[2:0] == 3'd0) && (fy < VA9);
    load   = (x[2:0] == 3'd7) && (nx < HA9) && (ny < VA9);
    active = (x < HA9) && (y < VA9);
    hs_on  = (x >= HS09) && (x < HS19);
    vs_on  = (y >= VS09) && (y < VS19);
  end

`ifdef LYNX_VFETCH_ALTGREEN_EN
  logic altg_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      altg_q <= 1'b0;
    end else if (ce && wrap_x) begin
      altg_q <= altg;
    end
  end

  // The line's first group loads on the same ce that samples altg.
  assign g_src = (wrap_x ? altg : altg_q) ? qa : qg;
`else
  assign g_src = qg;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x     <= 9'd0;
      y     <= 9'd0;
      a     <= 13'd0;
      sr    <= 8'd0;
      sg    <= 8'd0;
      sb    <= 8'd0;
      r     <= 1'b0;
      g     <= 1'b0;
      b     <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
    end else if (ce) begin
      x <= nx;
      y <= ny;
      if (fetch) begin
        a <= {fy[7:0], fx[7:3]};
      end
      if (x[2:0] == 3'd7) begin
        sr <= load ? qr    : 8'd0;
        sg <= load ? g_src : 8'd0;
        sb <= load ? qb    : 8'd0;
      end else begin
        sr <= {sr[6:0], 1'b0};
        sg <= {sg[6:0], 1'b0};
        sb <= {sb[6:0], 1'b0};
      end
      r     <= sr[7] & active;
      g     <= sg[7] & active;
      b     <= sb[7] & active;
      blank <= !active;
      hsync <= !hs_on;
      vsync <= !vs_on;
    end
  end

endmodule

// File: tb/tb_lynx_vfetch.sv
// Bench for lynx_vfetch on a reduced raster: constant vectors, address corners, and model-checked random runs.
module tb_lynx_vfetch;

  localparam int HA = 32, HT = 48, HS0 = 36, HS1 = 40;
  localparam int VA = 6, VT = 10, VS0 = 7, VS1 = 8;
  localparam int FR = HT * VT;
`ifdef LYNX_VFETCH_ALTGREEN_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic        clock, reset, ce, altg;
  logic [12:0] a;
  logic [7:0]  qr, qg, qb, qa;
  logic        r, g, b, hsync, vsync, blank;
  logic [5:0]  pix;

  logic [7:0] mem_r [0:8191];
  logic [7:0] mem_g [0:8191];
  logic [7:0] mem_b [0:8191];
  logic [7:0] mem_a [0:8191];
  bit         alt_line [0:127];

  int          vectors, miscompares, nce;
  logic [12:0] exp_a;

  assign qr  = mem_r[a];
  assign qg  = mem_g[a];
  assign qb  = mem_b[a];
  assign qa  = mem_a[a];
  assign pix = {r, g, b, hsync, vsync, blank};

  lynx_vfetch #(
    .HA(HA), .HT(HT), .HS0(HS0), .HS1(HS1),
    .VA(VA), .VT(VT), .VS0(VS0), .VS1(VS1)
  ) dut (
    .clock(clock), .reset(reset), .ce(ce), .a(a),
    .qr(qr), .qg(qg), .qb(qb),
`ifdef LYNX_VFETCH_ALTGREEN_EN
    .qa(qa), .altg(altg),
`endif
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .blank(blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    int         fr;
    int         y;
    int         x;
    logic [5:0] exp;   // {r,g,b,hsync,vsync,blank}
  } vec_t;
  vec_t tbl [14];

  // Pixel shown after ce number t since reset, from raster arithmetic.
  function automatic logic [5:0] ref_pix(input int t);
    int x, ln, y, fr, bi;
    logic act, on;
    logic [12:0] ad;
    logic [7:0] gb;
    x   = t % HT;
    ln  = t / HT;
    y   = ln % VT;
    fr  = t / FR;
    act = (x < HA) && (y < VA);
    on  = act && !(fr == 0 && y == 0 && x < 8);
    ad  = 13'(y * 32 + x / 8);
    bi  = 7 - (x % 8);
    gb  = (ln < 128 && alt_line[ln]) ? mem_a[ad] : mem_g[ad];
    return {on & mem_r[ad][bi], on & gb[bi], on & mem_b[ad][bi],
            !(x >= HS0 && x < HS1), !(y >= VS0 && y < VS1), !act};
  endfunction

  // A fetch issued on ce t targets the raster position two ces later.
  task automatic upd_addr(input int t);
    int s, sx, sy;
    s  = t + 2;
    sx = s % HT;
    sy = (s / HT) % VT;
    if (sx < HA && sx % 8 == 0 && sy < VA) exp_a = 13'(sy * 32 + sx / 8);
  endtask

  task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s (ce %0d): got %h expected %h", nm, nce, got, want);
    end
  endtask

  task automatic clear_model();
    nce   = 0;
    exp_a = 13'd0;
    for (int i = 0; i < 128; i++) alt_line[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ce    = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    clear_model();
  endtask

  task automatic step(input logic c);
    ce = c;
    @(posedge clock);
    #1;
    if (c) begin
      if (nce % HT == HT - 1 && nce / HT + 1 < 128) alt_line[nce / HT + 1] = altg & ALT;
      upd_addr(nce);
      nce++;
    end
  endtask

  task automatic rstep(input logic c);
    step(c);
    chk("addr", a, exp_a);
    if (c) chk("pixel", {7'd0, pix}, {7'd0, ref_pix(nce - 1)});
  endtask

  task automatic run_to(input int t);
    while (nce <= t) step(1'b1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    altg = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      mem_r[i] = 8'h00; mem_g[i] = 8'h00; mem_b[i] = 8'h00; mem_a[i] = 8'h00;
    end
    mem_r[0] = 8'h80;
    mem_g[0] = 8'h01;
    mem_b[0] = 8'hFF;

    // Reset state and address corners.
    do_reset();
    chk("reset_pix", {7'd0, pix}, 13'h007);
    chk("reset_a", a, 13'd0);
    run_to(5);          chk("a_before_first_fetch", a, 13'h000);
    run_to(6);          chk("a_first_fetch", a, 13'h001);
    run_to(FR - 3);     chk("a_hold_after_last_line", a, 13'h0A3);
    run_to(FR - 2);     chk("a_frame_wrap_ahead", a, 13'h000);

    tbl[0]  = '{"f0_l0_x0_skipped", 0, 0, 0,   6'b000_110};
    tbl[1]  = '{"f0_l0_x5_skipped", 0, 0, 5,   6'b000_110};
    tbl[2]  = '{"f0_x_HA_blank",    0, 0, HA,  6'b000_111};
    tbl[3]  = '{"f0_hsync_start",   0, 0, HS0, 6'b000_011};
    tbl[4]  = '{"f0_hsync_last",    0, 0, HS1-1, 6'b000_011};
    tbl[5]  = '{"f0_hsync_end",     0, 0, HS1, 6'b000_111};
    tbl[6]  = '{"f0_vsync_start",   0, VS0, 0, 6'b000_101};
    tbl[7]  = '{"f0_vsync_end",     0, VS1, 0, 6'b000_111};
    tbl[8]  = '{"f1_l0_px0",        1, 0, 0,   6'b101_110};
    tbl[9]  = '{"f1_l0_px3",        1, 0, 3,   6'b001_110};
    tbl[10] = '{"f1_l0_px7",        1, 0, 7,   6'b011_110};
    tbl[11] = '{"f1_l0_px8",        1, 0, 8,   6'b000_110};
    tbl[12] = '{"f1_last_active",   1, VA-1, HA-1, 6'b000_110};
    tbl[13] = '{"f1_first_vblank",  1, VA, 0,  6'b000_111};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      run_to(tbl[i].fr * FR + tbl[i].y * HT + tbl[i].x);
      chk(tbl[i].nm, {7'd0, pix}, {7'd0, tbl[i].exp});
    end

`ifdef LYNX_VFETCH_ALTGREEN_EN
    for (int i = 0; i < 8192; i++) begin
      mem_r[i] = 8'h00; mem_g[i] = 8'h00; mem_b[i] = 8'h00; mem_a[i] = 8'hFF;
    end
    do_reset();
    run_to(2 * HT + HT - 2);
    altg = 1'b1;
    run_to(2 * HT + HT - 1);
    altg = 1'b0;
    run_to(3 * HT);          chk("altg_line_start", {12'd0, g}, 13'd1);
    run_to(3 * HT + HA - 1); chk("altg_line_end", {12'd0, g}, 13'd1);
    run_to(4 * HT);          chk("altg_off_next_line", {12'd0, g}, 13'd0);
`endif

    for (int i = 0; i < 8192; i++) begin
      mem_r[i] = 8'($urandom); mem_g[i] = 8'($urandom);
      mem_b[i] = 8'($urandom); mem_a[i] = 8'($urandom);
    end

    // ce one clock in four.
    do_reset();
    for (int i = 0; i < (2 * FR + 20) * 4; i++) begin
      altg = 1'($urandom_range(0, 1));
      rstep(i % 4 == 0);
    end

    // Random ce, then reset mid-line and check two further frames.
    do_reset();
    for (int i = 0; i < 20000 && nce < FR + 3 * HT + 21; i++) begin
      altg = 1'($urandom_range(0, 1));
      rstep(1'($urandom_range(0, 1)));
    end
    chk("pre_reset_pos", 13'(nce), 13'(FR + 3 * HT + 21));
    reset = 1'b0;
    #1;
    chk("midline_reset_pix", {7'd0, pix}, 13'h007);
    chk("midline_reset_a", a, 13'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    clear_model();
    for (int i = 0; i < 2 * FR + 10; i++) begin
      altg = 1'($urandom_range(0, 1));
      rstep(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
